// File: rtl/mult_pkg.sv
// Shared types and constants for the shared-multiplier arbiter.
package mult_pkg;

    localparam int OPW    = 8;   // operand width
    localparam int PRODW  = 16;  // product width
    localparam int IDMAXW = 3;   // id storage, enough for up to 8 requesters

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef struct packed {
        logic [OPW-1:0]    multiplier;
        logic [OPW-1:0]    multiplicand;
        logic [IDMAXW-1:0] id;
    } mult_req_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: first set request at or
// after the pointer, wrapping at NREQ (not at 2^IDW).
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [IDW-1:0]  o_idx,
    output logic            o_any
);

    int              w_j;
    logic [IDW-1:0]  w_jidx;

    // Scan from farthest to nearest so the nearest hit is written last.
    always_comb begin
        o_gnt  = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        w_j    = 0;
        w_jidx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_j    = (int'(i_ptr) + k) % NREQ;
            w_jidx = IDW'(w_j);
            if (i_req[w_jidx]) begin
                o_any = 1'b1;
                o_idx = w_jidx;
                o_gnt = NREQ'(1) << w_j;
            end
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one sequential signed multiplier among
// NREQ requesters, with a done-or-timeout wait and a held response.
module mult_arbiter
    import mult_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 31
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [NREQ-1:0]      i_req_valid,
    output logic [NREQ-1:0]      o_req_ready,
    input  logic [NREQ*OPW-1:0]  i_req_multiplier,
    input  logic [NREQ*OPW-1:0]  i_req_multiplicand,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic [IDW-1:0]       o_rsp_id,
    output logic [PRODW-1:0]     o_rsp_product,
    output logic                 o_rsp_timeout,
    output logic                 o_mult_start,
    output logic [OPW-1:0]       o_mult_multiplier,
    output logic [OPW-1:0]       o_mult_multiplicand,
    input  logic [PRODW-1:0]     i_mult_product,
    input  logic                 i_mult_done,
    output logic                 o_busy
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t             r_state;
    logic [IDW-1:0]     r_ptr;
    mult_req_t          r_req;
    logic [PRODW-1:0]   r_rsp_product;
    logic               r_rsp_timeout;
    logic [CW-1:0]      r_cnt;

    logic [NREQ-1:0]    w_gnt;
    logic [IDW-1:0]     w_idx;
    logic               w_any;
    logic               w_unused_id;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .i_req (i_req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    // Grant is offered only while idle and out of reset; the transfer
    // happens in the same cycle.
    assign o_req_ready         = (r_state == ST_IDLE && i_rst_n) ? w_gnt : '0;
    assign o_mult_start        = (r_state == ST_START);
    assign o_busy              = (r_state != ST_IDLE);
    assign o_rsp_valid         = (r_state == ST_RESP);
    assign o_rsp_id            = r_req.id[IDW-1:0];
    assign o_rsp_product       = r_rsp_product;
    assign o_rsp_timeout       = r_rsp_timeout;
    assign o_mult_multiplier   = r_req.multiplier;
    assign o_mult_multiplicand = r_req.multiplicand;
    assign w_unused_id         = ^r_req.id;

    // Control FSM: grant/latch, start pulse, wait for done or timeout, respond.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_ptr         <= '0;
            r_req         <= '0;
            r_rsp_product <= '0;
            r_rsp_timeout <= 1'b0;
            r_cnt         <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_req.multiplier   <= i_req_multiplier[w_idx*OPW +: OPW];
                        r_req.multiplicand <= i_req_multiplicand[w_idx*OPW +: OPW];
                        r_req.id           <= IDMAXW'(w_idx);
                        r_ptr              <= (w_idx == IDW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
                        r_state            <= ST_START;
                    end
                end
                ST_START: begin
                    r_cnt   <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    // A done seen on the first wait cycle may be left over
                    // from the previous operation, so it is not trusted.
                    if (i_mult_done && r_cnt != '0) begin
                        r_rsp_product <= i_mult_product;
                        r_rsp_timeout <= 1'b0;
                        r_state       <= ST_RESP;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_rsp_product <= '0;
                        r_rsp_timeout <= 1'b1;
                        r_state       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (i_rsp_ready) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
Shares one sequential 8x8 signed Robertson multiplier among NREQ requesters. Requesters present operand pairs with a valid/ready handshake. The arbiter grants round-robin, latches the winner's operands and pulses the multiplier's start. It then waits for the multiplier's done flag, or for a timeout, and returns the 16-bit product tagged with the requester id. It sits between client blocks and the multiplier, in place of a direct top-level hookup.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, id width; must equal clog2(NREQ)
TIMEOUT, 31, max cycles to wait for mult_done before aborting

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  NREQ  requester i has an operand pair
req_ready  out  NREQ  one-hot grant/accept, high only in IDLE for the winner
req_multiplier  in  NREQ*8  packed multiplier operands, slot i = bits [8i+7:8i]
req_multiplicand  in  NREQ*8  packed multiplicand operands
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_id  out  IDW  requester index of the response
rsp_product  out  16  signed product; 0 on timeout
rsp_timeout  out  1  response is an abort, not a product
mult_start  out  1  one-cycle start pulse to the multiplier (drives its start/reset input)
mult_multiplier  out  8  latched operand, held stable from START until the next grant
mult_multiplicand  out  8  latched operand, held stable likewise
mult_product  in  16  multiplier result
mult_done  in  1  multiplier complete flag
busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-low.
- Reset values (async, reset low):
  - state=IDLE, rr_ptr=0.
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_product=0, rsp_timeout=0.
  - mult_start=0, mult_multiplier=0, mult_multiplicand=0, busy=0, timeout counter=0.
- FSM states: IDLE, START, WAIT, RESP.
- IDLE:
  - Round-robin pick: the first i with req_valid[i] set, scanning from rr_ptr upward with wrap.
  - Winner found: req_ready[winner]=1 combinationally; the transfer occurs that cycle.
  - On the transfer: latch both operands and id; rr_ptr <= winner+1 mod NREQ; go to START.
  - No valid requester: stay in IDLE; rr_ptr unchanged.
- START:
  - mult_start=1 for exactly one cycle; timeout counter cleared to 0.
  - Next state WAIT.
- WAIT:
  - Counter increments each cycle.
  - mult_done=1: capture mult_product into rsp_product; rsp_timeout=0; go to RESP.
  - Counter reaches TIMEOUT with no done: rsp_product=0; rsp_timeout=1; go to RESP.
  - mult_done sampled in the same cycle the counter hits TIMEOUT: done wins.
  - mult_done is ignored in START, and in WAIT during the first cycle after START, to mask a stale done from the previous op.
- RESP:
  - rsp_valid=1; rsp_id, rsp_product and rsp_timeout held stable until rsp_ready.
  - rsp_valid & rsp_ready: rsp_valid drops next cycle; go to IDLE.
  - A new grant can occur no earlier than the cycle after the RESP handshake.
- Minimum latency, grant to rsp_valid: 2 + multiplier latency cycles.
- Requests arriving outside IDLE see req_ready=0 and are held by the requester.
- A requester may drop req_valid before grant; no state is affected.
- Reset asserted mid-operation aborts everything; no response is produced for the in-flight request.
- Operand signedness passes through unchanged; the arbiter does no arithmetic except the counter and pointer wrap.
- NREQ not a power of two: rr_ptr wraps at NREQ, never at 2^IDW.

Decomposition:
- Shared package mult_pkg:
  - state enum (IDLE, START, WAIT, RESP);
  - localparams OPW=8 and PRODW=16;
  - packed struct mult_req_t holding multiplier, multiplicand and id.
- One natural sub-module: rr_pick.
  - Purely combinational round-robin priority encoder.
  - Inputs: req vector and pointer. Outputs: grant one-hot, grant index, any flag.
  - Reusable by other shared-resource controllers.
- Bench instantiates mult_arbiter with the real robsmult, and a stub multiplier for the timeout tests.

Test Plan:
- Single request: req 0 sends 7 x -3, rsp_ready held high -> rsp_valid with rsp_id=0, rsp_product=16'hFFEB, rsp_timeout=0, mult_start pulsed once.
- All four requesters valid continuously, with operands i x (i+1) -> grant order 0,1,2,3,0; products 0,2,6,12; no requester starved.
- Backpressure: rsp_ready held low 10 cycles after rsp_valid -> outputs stable, req_ready all 0, busy=1; a later handshake returns to IDLE.
- Stub multiplier never asserts done, TIMEOUT=31 -> rsp_valid exactly 33 cycles after grant, with rsp_timeout=1 and rsp_product=0.
- mult_done asserted on the same cycle the counter reaches TIMEOUT -> rsp_timeout=0 and the product is captured.
- reset pulled low during WAIT, with req 2 pending -> all outputs return to reset values immediately; after release, grant goes to req 2 with rr_ptr=0 scan order.
